mprj_io_stim_ctrl: RTL and testbench
====================================

# mprj_io_stim_ctrl

Management-side controller for the 38 user-project IO pads (mprj_io) of the SoC, with a built-in user-project stimulus source. A simple single-master register bus lets firmware drive pad values, choose per pad between management and user control, and set output enables. It can also read back pad inputs and step a user-side counter that drives pads [31:16]. Firmware uses it to publish check words on mprj_io[31:16] and status nibbles on mprj_io[37:34].

## Interface
Parameters
- NUM_IO, 38: number of pads (fixed at 38; the register map assumes it).

Ports
- clock  in  1  system clock; all state updates on rising edge.
- resetb  in  1  asynchronous, active-low reset.
- bus_cyc  in  1  bus cycle valid.
- bus_stb  in  1  strobe; request = bus_cyc & bus_stb, held until ack.
- bus_we  in  1  1 = write, 0 = read.
- bus_adr  in  4  word index of the register.
- bus_dat_i  in  32  write data.
- bus_dat_o  out  32  read data; valid only while bus_ack = 1.
- bus_ack  out  1  single-cycle acknowledge.
- mprj_io_in  in  38  pad input values.
- mprj_io_out  out  38  pad output values.
- mprj_io_oeb  out  38  pad output-enable, active low (1 = pad is an input).

## Operation
Register map (word index):
- 0 DATA_LO: management output data for pads [31:0].
- 1 DATA_HI: management output data for pads [37:32], held in bits [5:0].
- 2 SEL_LO: per-pad select for [31:0]; 1 = user drives the pad.
- 3 SEL_HI: per-pad select for [37:32].
- 4 OEB_LO: management oeb for [31:0].
- 5 OEB_HI: management oeb for [37:32].
- 6 USER_CNT: read returns {16'b0, cnt}. Write bit0 = step (cnt+1), bit1 = clear.
- 7 IN_LO: read-only, returns mprj_io_in[31:0].
- 8 IN_HI: read-only, returns mprj_io_in[37:32] in bits [5:0].
- 9–15: reserved. Reads return 0, writes are ignored, and ack is still given.

Register field behaviour:
- HI registers read their unused upper bits as 0; writes to those bits are ignored.
- Writes to read-only registers are ignored.

User stimulus source:
- user_out[31:16] = cnt. All other user_out bits = 0.
- user_oeb[31:16] = 0. All other user_oeb bits = 1.

Pad mux, per pad i:
- mprj_io_out[i] = sel[i] ? user_out[i] : data[i]
- mprj_io_oeb[i] = sel[i] ? user_oeb[i] : oeb[i]

Counter rules:
- cnt is 16 bits and wraps 0xFFFF -> 0x0000.
- If step and clear are set in the same write, clear wins and cnt = 0.

## Timing
- Reset values: data = 0, sel = 0, oeb = all 1, cnt = 0, bus_ack = 0, bus_dat_o = 0. Result: mprj_io_out = 0 and mprj_io_oeb = all 1s.
- bus_ack is registered. It rises on the first edge after a request is seen and stays high for exactly one cycle. It is not reasserted for the same request in the following cycle, so back-to-back transactions give at most one ack every 2 cycles.
- A write updates its register on the same edge that raises bus_ack. The mprj_io_out/oeb outputs are combinational from registers, so they reflect the write in the ack cycle.
- Read data is captured at the acking edge. IN_LO/IN_HI sample mprj_io_in at that edge; there is no synchroniser, and firmware is responsible for that.
- If the request drops before ack, no ack is produced and no write happens.
- Reset asserted mid-transaction aborts it immediately and sets all state to the reset values.

## Configuration
- USER_STIM_EN defined: the user counter and its user_out/user_oeb drive exist as described.
- USER_STIM_EN undefined: there is no counter. user_out = 0, user_oeb = all 1, USER_CNT reads 0, and writes to USER_CNT are ignored. The pad mux and all other registers are unchanged.

## Test plan
- Reset: hold resetb low, then release. Check mprj_io_oeb = 38'h3F_FFFF_FFFF, mprj_io_out = 0, and all registers read their reset values.
- Check word: write OEB_LO = 0 and DATA_LO = 0xAB40_0000. Check mprj_io_out[31:16] = 0xAB40 in the ack cycle, with ack high for exactly 1 cycle.
- Status nibbles: write OEB_HI = 0, then DATA_HI = 6'h28. Check mprj_io_out[37:34] = 4'hA. Then write DATA_HI = 6'h14 and check 4'h5.
- User loopback (USER_STIM_EN defined):
  - Write SEL_LO = 0xFFFF_0000, then nine writes of USER_CNT = 1. Check mprj_io_out[31:16] = 0x0009 and USER_CNT reads 0x0009.
  - Write SEL_LO = 0 and DATA_LO = 0x0009_0000. Check pads still show 0x0009.
  - Write DATA_LO = 0xAB51_0000 and check 0xAB51.
- Counter edges: write USER_CNT = 3 and check cnt = 0. Drive cnt to 0xFFFF with 65535 steps, step once more, and check it reads 0x0000.
- Inputs and reserved space: drive mprj_io_in = 38'h2A_5A5A_5A5A. Check IN_LO = 0x5A5A_5A5A and IN_HI = 0x2A. Check that a read of index 12 returns 0 with ack.

Source files
------------

// File: rtl/mprj_io_stim_ctrl.sv
// mprj_io_stim_ctrl
// Management-side controller for the 38 user-project IO pads. A small
// single-master register bus sets per-pad output data, output enables and
// management/user select, and reads back the pad inputs. A user-side
// stimulus counter can drive pads [31:16] when selected.
//
// Build option: define USER_STIM_EN to include the user stimulus counter.
// Without it, user_out is all 0, user_oeb is all 1, USER_CNT reads 0 and
// writes to USER_CNT are ignored.
//
// Bus handshake: a request is bus_cyc & bus_stb, held by the master until
// bus_ack. bus_ack is registered, rises on the first clock edge that sees
// the request and lasts exactly one cycle; it is never raised two cycles in
// a row, so a request still held in the ack cycle is treated as a new
// transaction one cycle later. Writes take effect on the acking edge and
// read data is captured on that same edge (bus_dat_o is 0 outside of a
// read ack).

module mprj_io_stim_ctrl #(
    parameter int NUM_IO = 38
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              bus_cyc,
    input  logic              bus_stb,
    input  logic              bus_we,
    input  logic [3:0]        bus_adr,
    input  logic [31:0]       bus_dat_i,
    output logic [31:0]       bus_dat_o,
    output logic              bus_ack,
    input  logic [NUM_IO-1:0] mprj_io_in,
    output logic [NUM_IO-1:0] mprj_io_out,
    output logic [NUM_IO-1:0] mprj_io_oeb
);

    localparam int HI_W = NUM_IO - 32;

    localparam logic [3:0] ADR_DATA_LO  = 4'd0;
    localparam logic [3:0] ADR_DATA_HI  = 4'd1;
    localparam logic [3:0] ADR_SEL_LO   = 4'd2;
    localparam logic [3:0] ADR_SEL_HI   = 4'd3;
    localparam logic [3:0] ADR_OEB_LO   = 4'd4;
    localparam logic [3:0] ADR_OEB_HI   = 4'd5;
    localparam logic [3:0] ADR_USER_CNT = 4'd6;
    localparam logic [3:0] ADR_IN_LO    = 4'd7;
    localparam logic [3:0] ADR_IN_HI    = 4'd8;

    logic              req;
    logic              fire;
    logic              wr_fire;
    logic [31:0]       rd_data;
    logic [NUM_IO-1:0] data;
    logic [NUM_IO-1:0] sel;
    logic [NUM_IO-1:0] oeb;
    logic [NUM_IO-1:0] user_out;
    logic [NUM_IO-1:0] user_oeb;
    logic [15:0]       cnt_rd;

    // A transaction is accepted on an edge where the request is present and
    // the previous cycle was not already an ack for it.
    assign req     = bus_cyc & bus_stb;
    assign fire    = req & ~bus_ack;
    assign wr_fire = fire & bus_we;

    // Bus acknowledge and read-data capture at the accepting edge.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            bus_ack   <= 1'b0;
            bus_dat_o <= '0;
        end else begin
            bus_ack   <= fire;
            bus_dat_o <= (fire && !bus_we) ? rd_data : '0;
        end
    end

    // Management data, select and output-enable registers.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            data <= '0;
            sel  <= '0;
            oeb  <= '1;
        end else if (wr_fire) begin
            case (bus_adr)
                ADR_DATA_LO: data[31:0]        <= bus_dat_i;
                ADR_DATA_HI: data[NUM_IO-1:32] <= bus_dat_i[HI_W-1:0];
                ADR_SEL_LO:  sel[31:0]         <= bus_dat_i;
                ADR_SEL_HI:  sel[NUM_IO-1:32]  <= bus_dat_i[HI_W-1:0];
                ADR_OEB_LO:  oeb[31:0]         <= bus_dat_i;
                ADR_OEB_HI:  oeb[NUM_IO-1:32]  <= bus_dat_i[HI_W-1:0];
                default: ;
            endcase
        end
    end

`ifdef USER_STIM_EN
    logic [15:0] cnt;

    // User stimulus counter: bit1 clears (and wins over step), bit0 steps
    // with natural 16-bit wrap.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt <= '0;
        end else if (wr_fire && bus_adr == ADR_USER_CNT) begin
            if (bus_dat_i[1]) begin
                cnt <= '0;
            end else if (bus_dat_i[0]) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    assign cnt_rd   = cnt;
    assign user_out = {{HI_W{1'b0}}, cnt, 16'h0000};
    assign user_oeb = {{HI_W{1'b1}}, 16'h0000, 16'hFFFF};
`else
    assign cnt_rd   = '0;
    assign user_out = '0;
    assign user_oeb = '1;
`endif

    // Register read mux; reserved indices and unused upper bits read 0.
    always_comb begin
        rd_data = '0;
        case (bus_adr)
            ADR_DATA_LO:  rd_data            = data[31:0];
            ADR_DATA_HI:  rd_data[HI_W-1:0]  = data[NUM_IO-1:32];
            ADR_SEL_LO:   rd_data            = sel[31:0];
            ADR_SEL_HI:   rd_data[HI_W-1:0]  = sel[NUM_IO-1:32];
            ADR_OEB_LO:   rd_data            = oeb[31:0];
            ADR_OEB_HI:   rd_data[HI_W-1:0]  = oeb[NUM_IO-1:32];
            ADR_USER_CNT: rd_data[15:0]      = cnt_rd;
            ADR_IN_LO:    rd_data            = mprj_io_in[31:0];
            ADR_IN_HI:    rd_data[HI_W-1:0]  = mprj_io_in[NUM_IO-1:32];
            default: ;
        endcase
    end

    // Per-pad mux between management registers and the user source; purely
    // combinational so a write shows on the pads in its ack cycle.
    assign mprj_io_out = (sel & user_out) | (~sel & data);
    assign mprj_io_oeb = (sel & user_oeb) | (~sel & oeb);

endmodule

// File: tb/tb_mprj_io_stim_ctrl.sv
// tb_mprj_io_stim_ctrl
// Bench for mprj_io_stim_ctrl: directed vector table, hand-written
// multi-cycle sequences, then randomized bus traffic checked against a
// register-map level reference model. Define USER_STIM_EN for both the
// bench and the design to exercise the user counter.

module tb_mprj_io_stim_ctrl;

`ifdef USER_STIM_EN
    localparam bit STIM = 1'b1;
`else
    localparam bit STIM = 1'b0;
`endif

    localparam logic [37:0] ALL1 = 38'h3F_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        bus_cyc = 1'b0;
    logic        bus_stb = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_adr = '0;
    logic [31:0] bus_dat_i = '0;
    logic [31:0] bus_dat_o;
    logic        bus_ack;
    logic [37:0] mprj_io_in = '0;
    logic [37:0] mprj_io_out;
    logic [37:0] mprj_io_oeb;

    int checks = 0;
    int errors = 0;

    logic [31:0] ack_rd;
    logic [37:0] ack_out;
    logic [37:0] ack_oeb;
    logic [31:0] exp_q[$];

    // Reference model state
    logic [37:0] m_data;
    logic [37:0] m_sel;
    logic [37:0] m_oeb;
    int          m_cnt;

    mprj_io_stim_ctrl #(.NUM_IO(38)) dut (
        .clock       (clock),
        .resetb      (resetb),
        .bus_cyc     (bus_cyc),
        .bus_stb     (bus_stb),
        .bus_we      (bus_we),
        .bus_adr     (bus_adr),
        .bus_dat_i   (bus_dat_i),
        .bus_dat_o   (bus_dat_o),
        .bus_ack     (bus_ack),
        .mprj_io_in  (mprj_io_in),
        .mprj_io_out (mprj_io_out),
        .mprj_io_oeb (mprj_io_oeb)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetb  = 1'b0;
        bus_cyc = 1'b0;
        bus_stb = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out", mprj_io_out, 38'h0);
        check("rst_oeb", mprj_io_oeb, ALL1);
        check("rst_ack", bus_ack, 1'b0);
        check("rst_dat", bus_dat_o, 32'h0);
        @(negedge clock);
        resetb = 1'b1;
    endtask

    // One bus transaction; captures read data and pad state in the ack cycle
    task automatic xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat);
        bit got;
        got     = 1'b0;
        ack_rd  = 'x;
        ack_out = 'x;
        ack_oeb = 'x;
        @(negedge clock);
        bus_cyc   = 1'b1;
        bus_stb   = 1'b1;
        bus_we    = we;
        bus_adr   = adr;
        bus_dat_i = wdat;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clock);
            #1;
            if (bus_ack) begin
                got     = 1'b1;
                ack_rd  = bus_dat_o;
                ack_out = mprj_io_out;
                ack_oeb = mprj_io_oeb;
            end
        end
        bus_cyc = 1'b0;
        bus_stb = 1'b0;
        bus_we  = 1'b0;
        check("ack_seen", got, 1'b1);
        @(posedge clock);
        #1;
        check("ack_width", bus_ack, 1'b0);
    endtask

    // ---------------- reference model ----------------
    function automatic void m_reset();
        m_data = '0;
        m_sel  = '0;
        m_oeb  = ALL1;
        m_cnt  = 0;
    endfunction

    function automatic void m_write(input logic [3:0] adr, input logic [31:0] d);
        case (adr)
            4'd0: m_data[31:0]  = d;
            4'd1: m_data[37:32] = d[5:0];
            4'd2: m_sel[31:0]   = d;
            4'd3: m_sel[37:32]  = d[5:0];
            4'd4: m_oeb[31:0]   = d;
            4'd5: m_oeb[37:32]  = d[5:0];
            4'd6: begin
                if (STIM && d[1]) m_cnt = 0;
                else if (STIM && d[0]) m_cnt = (m_cnt + 1) % 65536;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] adr, input logic [37:0] pin);
        logic [31:0] r;
        r = 32'h0;
        if (adr == 4'd0) r = m_data[31:0];
        if (adr == 4'd1) r = 32'(m_data[37:32]);
        if (adr == 4'd2) r = m_sel[31:0];
        if (adr == 4'd3) r = 32'(m_sel[37:32]);
        if (adr == 4'd4) r = m_oeb[31:0];
        if (adr == 4'd5) r = 32'(m_oeb[37:32]);
        if (adr == 4'd6) r = STIM ? 32'(m_cnt) : 32'h0;
        if (adr == 4'd7) r = pin[31:0];
        if (adr == 4'd8) r = 32'(pin[37:32]);
        return r;
    endfunction

    // Pad value seen when the user source owns pad i
    function automatic logic user_bit_out(input int i);
        if (STIM && i >= 16 && i < 32) return 1'((m_cnt >> (i - 16)) & 1);
        return 1'b0;
    endfunction

    function automatic logic user_bit_oeb(input int i);
        if (STIM && i >= 16 && i < 32) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [37:0] m_pad_out();
        logic [37:0] r;
        for (int i = 0; i < 38; i++) r[i] = m_sel[i] ? user_bit_out(i) : m_data[i];
        return r;
    endfunction

    function automatic logic [37:0] m_pad_oeb();
        logic [37:0] r;
        for (int i = 0; i < 38; i++) r[i] = m_sel[i] ? user_bit_oeb(i) : m_oeb[i];
        return r;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] wdat;
        logic [37:0] pin;
        logic [31:0] exp_rd;
        logic [37:0] exp_out;
        logic [37:0] exp_oeb;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                                input logic [37:0] pin, input logic [31:0] exp_rd,
                                input logic [37:0] exp_out, input logic [37:0] exp_oeb);
        vec_t v;
        v.we = we; v.adr = adr; v.wdat = wdat; v.pin = pin;
        v.exp_rd = exp_rd; v.exp_out = exp_out; v.exp_oeb = exp_oeb;
        return v;
    endfunction

    localparam logic [37:0] PIN_A = 38'h2A_5A5A_5A5A;
    localparam logic [37:0] OUT_W = 38'h00_AB40_0000;

    initial begin
        logic [37:0] pin_r;
        logic [3:0]  adr_r;
        logic [31:0] dat_r;
        logic        we_r;
        logic [31:0] exp_r;
        int          acks;

        // reset values read through the bus
        vt.push_back(mk(0, 4'd0,  0, 0, 32'h0,        38'h0, ALL1));
        vt.push_back(mk(0, 4'd1,  0, 0, 32'h0,        38'h0, ALL1));
        vt.push_back(mk(0, 4'd2,  0, 0, 32'h0,        38'h0, ALL1));
        vt.push_back(mk(0, 4'd3,  0, 0, 32'h0,        38'h0, ALL1));
        vt.push_back(mk(0, 4'd4,  0, 0, 32'hFFFF_FFFF, 38'h0, ALL1));
        vt.push_back(mk(0, 4'd5,  0, 0, 32'h3F,       38'h0, ALL1));
        vt.push_back(mk(0, 4'd6,  0, 0, 32'h0,        38'h0, ALL1));
        // check word on [31:16]
        vt.push_back(mk(1, 4'd4,  32'h0, 0, 0, 38'h0, 38'h3F_0000_0000));
        vt.push_back(mk(1, 4'd0,  32'hAB40_0000, 0, 0, OUT_W, 38'h3F_0000_0000));
        vt.push_back(mk(0, 4'd0,  0, 0, 32'hAB40_0000, OUT_W, 38'h3F_0000_0000));
        // status nibbles on [37:34]
        vt.push_back(mk(1, 4'd5,  32'h0,  0, 0, OUT_W, 38'h0));
        vt.push_back(mk(1, 4'd1,  32'h28, 0, 0, 38'h28_AB40_0000, 38'h0));
        vt.push_back(mk(1, 4'd1,  32'h14, 0, 0, 38'h14_AB40_0000, 38'h0));
        vt.push_back(mk(0, 4'd1,  0, 0, 32'h14, 38'h14_AB40_0000, 38'h0));
        // unused HI bits ignored on write, read as 0
        vt.push_back(mk(1, 4'd1,  32'hFFFF_FFC0, 0, 0, OUT_W, 38'h0));
        vt.push_back(mk(0, 4'd1,  0, 0, 32'h0, OUT_W, 38'h0));
        vt.push_back(mk(1, 4'd5,  32'hFFFF_FFF0, 0, 0, OUT_W, 38'h30_0000_0000));
        vt.push_back(mk(0, 4'd5,  0, 0, 32'h30, OUT_W, 38'h30_0000_0000));
        // read-only and reserved space
        vt.push_back(mk(1, 4'd7,  32'h1234_5678, 0, 0, OUT_W, 38'h30_0000_0000));
        vt.push_back(mk(1, 4'd13, 32'hDEAD_BEEF, 0, 0, OUT_W, 38'h30_0000_0000));
        vt.push_back(mk(0, 4'd12, 0, 0, 32'h0, OUT_W, 38'h30_0000_0000));
        vt.push_back(mk(0, 4'd7,  0, PIN_A, 32'h5A5A_5A5A, OUT_W, 38'h30_0000_0000));
        vt.push_back(mk(0, 4'd8,  0, PIN_A, 32'h2A, OUT_W, 38'h30_0000_0000));
        vt.push_back(mk(0, 4'd15, 0, PIN_A, 32'h0, OUT_W, 38'h30_0000_0000));
        // user select on pads [7:0]: user side never drives them
        vt.push_back(mk(1, 4'd2,  32'hFF, 0, 0, OUT_W, 38'h30_0000_00FF));
        vt.push_back(mk(0, 4'd2,  0, 0, 32'hFF, OUT_W, 38'h30_0000_00FF));
        vt.push_back(mk(1, 4'd2,  32'h0, 0, 0, OUT_W, 38'h30_0000_0000));

        do_reset();

        foreach (vt[k]) begin
            mprj_io_in = vt[k].pin;
            xfer(vt[k].we, vt[k].adr, vt[k].wdat);
            if (!vt[k].we) check($sformatf("vec%0d_rd", k), ack_rd, vt[k].exp_rd);
            check($sformatf("vec%0d_out", k), ack_out, vt[k].exp_out);
            check($sformatf("vec%0d_oeb", k), ack_oeb, vt[k].exp_oeb);
        end
        mprj_io_in = '0;

        // user loopback: nine steps onto pads [31:16]
        xfer(1, 4'd2, 32'hFFFF_0000);
        check("loop_sel_oeb", ack_oeb[31:16], STIM ? 16'h0000 : 16'hFFFF);
        repeat (9) xfer(1, 4'd6, 32'h1);
        check("loop_pads9", ack_out[31:16], STIM ? 16'h0009 : 16'h0000);
        xfer(0, 4'd6, 0);
        check("loop_cnt9", ack_rd, STIM ? 32'h9 : 32'h0);
        xfer(1, 4'd2, 32'h0);
        xfer(1, 4'd0, 32'h0009_0000);
        check("loop_mgmt9", ack_out[31:16], 16'h0009);
        xfer(1, 4'd0, 32'hAB51_0000);
        check("loop_ab51", ack_out[31:16], 16'hAB51);

        // step and clear together: clear wins
        xfer(1, 4'd6, 32'h3);
        xfer(0, 4'd6, 0);
        check("cnt_clear_wins", ack_rd, 32'h0);

        // request held: acks on alternate cycles, one step per ack
        @(negedge clock);
        bus_cyc = 1'b1; bus_stb = 1'b1; bus_we = 1'b1; bus_adr = 4'd6; bus_dat_i = 32'h1;
        acks = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (bus_ack) acks++;
        end
        bus_cyc = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
        check("b2b_acks", acks, 3);
        xfer(0, 4'd6, 0);
        check("b2b_cnt", ack_rd, STIM ? 32'h3 : 32'h0);

`ifdef USER_STIM_EN
        // wrap: preload 0xFFFF instead of 65535 bus steps, then step once
        @(negedge clock);
        force dut.cnt = 16'hFFFF;
        @(negedge clock);
        release dut.cnt;
        xfer(0, 4'd6, 0);
        check("wrap_pre", ack_rd, 32'hFFFF);
        xfer(1, 4'd6, 32'h1);
        xfer(0, 4'd6, 0);
        check("wrap_zero", ack_rd, 32'h0);
`endif

        // request dropped before the edge: no ack, no write
        @(negedge clock);
        bus_cyc = 1'b1; bus_stb = 1'b1; bus_we = 1'b1; bus_adr = 4'd0; bus_dat_i = 32'hFFFF_FFFF;
        #2;
        bus_cyc = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
        @(posedge clock);
        #1;
        check("drop_no_ack", bus_ack, 1'b0);
        xfer(0, 4'd0, 0);
        check("drop_no_write", ack_rd, 32'hAB51_0000);

        // reset in the middle of a pending write aborts it at once
        @(negedge clock);
        bus_cyc = 1'b1; bus_stb = 1'b1; bus_we = 1'b1; bus_adr = 4'd0; bus_dat_i = 32'hFFFF_FFFF;
        #2;
        resetb = 1'b0;
        #1;
        check("midrst_out", mprj_io_out, 38'h0);
        check("midrst_oeb", mprj_io_oeb, ALL1);
        @(posedge clock);
        #1;
        check("midrst_ack", bus_ack, 1'b0);
        bus_cyc = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
        xfer(0, 4'd0, 0);
        check("midrst_data", ack_rd, 32'h0);

        // randomized traffic against the model
        do_reset();
        m_reset();
        for (int n = 0; n < 300; n++) begin
            we_r  = 1'($urandom_range(0, 1));
            adr_r = 4'($urandom_range(0, 15));
            dat_r = $urandom;
            pin_r = {6'($urandom_range(0, 63)), 32'($urandom)};
            mprj_io_in = pin_r;
            if (!we_r) exp_q.push_back(m_read(adr_r, pin_r));
            else m_write(adr_r, dat_r);
            xfer(we_r, adr_r, dat_r);
            if (!we_r) begin
                exp_r = exp_q.pop_front();
                check($sformatf("rnd%0d_rd_a%0d", n, adr_r), ack_rd, exp_r);
            end
            check($sformatf("rnd%0d_out", n), ack_out, m_pad_out());
            check($sformatf("rnd%0d_oeb", n), ack_oeb, m_pad_oeb());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
